// File: rtl/fifo_port_arbiter.sv
// Two-producer round-robin write arbiter in front of an external FIFO, with a
// one-cycle read-return path, occupancy tracking and an almost-full interrupt.
module fifo_port_arbiter #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       p0_valid,
  input  logic [WIDTH-1:0]           p0_data,
  output logic                       p0_ready,
  input  logic                       p1_valid,
  input  logic [WIDTH-1:0]           p1_data,
  output logic                       p1_ready,
  input  logic                       c_req,
  output logic                       c_valid,
  output logic [WIDTH-1:0]           c_data,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_data_in,
  output logic                       fifo_rd_en,
  input  logic [WIDTH-1:0]           fifo_data_out,
  input  logic                       fifo_full,
  input  logic                       fifo_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       irq
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  logic [1:0]    valid_vec;
  logic [1:0]    grant_vec;
  logic [1:0]    ready_vec;
  logic          last_grant_reg;  // 0 = p0 granted last, 1 = p1 granted last
  logic          c_valid_reg;
  logic          irq_reg;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;

  assign valid_vec = {p1_valid, p0_valid};

  // On contention the producer not granted last wins; a lone requester always wins.
  always_comb begin
    grant_vec = 2'b00;
    if (!rst) begin
      if (valid_vec == 2'b11) begin
        grant_vec = last_grant_reg ? 2'b01 : 2'b10;
      end else begin
        grant_vec = valid_vec;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = grant_vec[gi] & ~fifo_full & ~rst;
    end
  endgenerate

  assign p0_ready     = ready_vec[0];
  assign p1_ready     = ready_vec[1];
  assign fifo_wr_en   = |ready_vec;
  assign fifo_data_in = grant_vec[0] ? p0_data :
                        grant_vec[1] ? p1_data : '0;
  assign fifo_rd_en   = c_req & ~fifo_empty & ~rst;

  assign c_valid = c_valid_reg;
  assign c_data  = c_valid_reg ? fifo_data_out : '0;
  assign level   = level_reg;
  assign irq     = irq_reg;

  always_comb begin
    level_next = level_reg;
    case ({fifo_wr_en, fifo_rd_en})
      2'b10:   level_next = level_reg + ONE_L;
      2'b01:   level_next = level_reg - ONE_L;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg      <= '0;
      c_valid_reg    <= 1'b0;
      irq_reg        <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      level_reg   <= level_next;
      c_valid_reg <= fifo_rd_en;
      irq_reg     <= (level_reg >= AF_L);
      // Only an accepted transfer moves the pointer; blocked grants leave it.
      if (fifo_wr_en) begin
        last_grant_reg <= ready_vec[1];
      end
    end
  end

  // The FIFO flags should make these unreachable; firing means flag/level disagreement.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_no_overflow:  assert (!(fifo_wr_en && !fifo_rd_en && level_reg == DEPTH_L));
      a_no_underflow: assert (!(fifo_rd_en && !fifo_wr_en && level_reg == '0));
    end
  end

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Directed bench for fifo_port_arbiter: a per-cycle vector table followed by
// a hand-written almost-full threshold and blocked-write sequence.
module tb_fifo_port_arbiter;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             p0_valid, p1_valid;
  logic [WIDTH-1:0] p0_data, p1_data;
  logic             p0_ready, p1_ready;
  logic             c_req, c_valid;
  logic [WIDTH-1:0] c_data;
  logic             fifo_wr_en, fifo_rd_en;
  logic [WIDTH-1:0] fifo_data_in, fifo_data_out;
  logic             fifo_full, fifo_empty;
  logic [LW-1:0]    level;
  logic             irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(12)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_data(p1_data), .p1_ready(p1_ready),
    .c_req(c_req), .c_valid(c_valid), .c_data(c_data),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .level(level), .irq(irq)
  );

  // dsel: which producer's data is expected on fifo_data_in (0 none, 1 p0, 2 p1).
  typedef struct {
    logic rst, p0v, p1v, creq, full, empty;
    logic ep0r, ep1r;
    int   dsel;
    logic erd, ecv;
    int   elvl;
    logic eirq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, p0v, p1v, creq, full, empty,
                     input logic ep0r, ep1r, input int dsel,
                     input logic erd, ecv, input int elvl, input logic eirq);
    vec_t v;
    v.rst = r; v.p0v = p0v; v.p1v = p1v; v.creq = creq; v.full = full; v.empty = empty;
    v.ep0r = ep0r; v.ep1r = ep1r; v.dsel = dsel; v.erd = erd; v.ecv = ecv;
    v.elvl = elvl; v.eirq = eirq;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; p0_valid = 0; p1_valid = 0; p0_data = '0; p1_data = '0;
    c_req = 0; fifo_full = 0; fifo_empty = 1; fifo_data_out = '0;

    //  rst p0v p1v creq full empty | p0r p1r dsel rd cv lvl irq
    add(1, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0);  // reset state, strobes held low
    add(0, 1, 1, 0, 0, 1,  1, 0, 1, 0, 0,  0, 0);  // contention: p0 first
    add(0, 1, 1, 0, 0, 1,  0, 1, 2, 0, 0,  1, 0);
    add(0, 1, 1, 0, 0, 1,  1, 0, 1, 0, 0,  2, 0);
    add(0, 1, 1, 0, 0, 1,  0, 1, 2, 0, 0,  3, 0);
    add(0, 0, 1, 0, 0, 1,  0, 1, 2, 0, 0,  4, 0);  // p1 alone x4
    add(0, 0, 1, 0, 0, 1,  0, 1, 2, 0, 0,  5, 0);
    add(0, 0, 1, 0, 0, 1,  0, 1, 2, 0, 0,  6, 0);
    add(0, 0, 1, 0, 0, 1,  0, 1, 2, 0, 0,  7, 0);
    add(0, 1, 1, 0, 1, 1,  0, 0, 1, 0, 0,  8, 0);  // full: blocked, p0 due
    add(0, 1, 1, 0, 1, 1,  0, 0, 1, 0, 0,  8, 0);
    add(0, 1, 1, 0, 0, 1,  1, 0, 1, 0, 0,  8, 0);  // full drops: p0 granted
    add(0, 1, 0, 0, 0, 1,  1, 0, 1, 0, 0,  9, 0);
    add(0, 0, 1, 0, 0, 1,  0, 1, 2, 0, 0, 10, 0);
    add(0, 1, 1, 0, 0, 1,  1, 0, 1, 0, 0, 11, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 12, 0);  // level 12, irq not yet
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 12, 1);
    add(0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 12, 1);  // one read
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 11, 1);
    add(0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 11, 0);
    add(0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1, 10, 0);
    add(0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1,  9, 0);
    add(0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1,  8, 0);
    add(0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1,  7, 0);
    add(0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1,  6, 0);
    add(0, 1, 0, 1, 0, 0,  1, 0, 1, 1, 1,  5, 0);  // write+read at level 5
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  5, 0);
    add(0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0,  5, 0);  // req while empty
    add(0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0,  5, 0);
    add(1, 1, 0, 1, 0, 0,  0, 0, 0, 0, 1,  4, 0);  // reset after read
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    add(0, 1, 1, 0, 0, 1,  1, 0, 1, 0, 0,  0, 0);  // pointer back to p0-first
    add(0, 1, 1, 1, 1, 0,  0, 0, 2, 1, 0,  1, 0);  // full + read: write blocked
    add(0, 1, 1, 0, 0, 0,  0, 1, 2, 0, 1,  0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      logic [WIDTH-1:0] exp_din;
      logic [WIDTH-1:0] exp_cd;
      @(negedge clk);
      rst = vecs[i].rst; p0_valid = vecs[i].p0v; p1_valid = vecs[i].p1v;
      c_req = vecs[i].creq; fifo_full = vecs[i].full; fifo_empty = vecs[i].empty;
      p0_data = 16'hA000 + 16'(i); p1_data = 16'hB000 + 16'(i);
      fifo_data_out = 16'h1000 + 16'(i);
      #1;
      exp_din = (vecs[i].dsel == 1) ? p0_data : (vecs[i].dsel == 2) ? p1_data : '0;
      exp_cd  = vecs[i].ecv ? fifo_data_out : '0;
      check("p0_ready", i, 32'(p0_ready), 32'(vecs[i].ep0r));
      check("p1_ready", i, 32'(p1_ready), 32'(vecs[i].ep1r));
      check("fifo_wr_en", i, 32'(fifo_wr_en), 32'(vecs[i].ep0r | vecs[i].ep1r));
      check("fifo_data_in", i, 32'(fifo_data_in), 32'(exp_din));
      check("fifo_rd_en", i, 32'(fifo_rd_en), 32'(vecs[i].erd));
      check("c_valid", i, 32'(c_valid), 32'(vecs[i].ecv));
      check("c_data", i, 32'(c_data), 32'(exp_cd));
      check("level", i, 32'(level), 32'(vecs[i].elvl));
      check("irq", i, 32'(irq), 32'(vecs[i].eirq));
    end

    // Hand sequence: fill to the threshold with p0 alone, then a blocked p1.
    @(negedge clk);
    rst = 1; p0_valid = 0; p1_valid = 0; c_req = 0; fifo_full = 0; fifo_empty = 1;
    @(negedge clk);
    rst = 0;
    #1;
    check("seq_level_reset", 100, 32'(level), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      p0_valid = 1; p0_data = 16'hC000 + 16'(i);
      #1;
      check("seq_p0_ready", 101 + i, 32'(p0_ready), 32'd1);
      check("seq_data_in", 101 + i, 32'(fifo_data_in), 32'(16'hC000 + 16'(i)));
      check("seq_level", 101 + i, 32'(level), 32'(i));
      check("seq_irq_low", 101 + i, 32'(irq), 32'd0);
    end
    @(negedge clk);
    p0_valid = 0; fifo_empty = 0;
    #1;
    check("seq_level12", 120, 32'(level), 32'd12);
    check("seq_irq_pending", 120, 32'(irq), 32'd0);
    @(negedge clk);
    p1_valid = 1; fifo_full = 1;
    #1;
    check("seq_irq_set", 121, 32'(irq), 32'd1);
    check("seq_p1_blocked", 121, 32'(p1_ready), 32'd0);
    check("seq_wr_blocked", 121, 32'(fifo_wr_en), 32'd0);
    @(negedge clk);
    #1;
    check("seq_level_held", 122, 32'(level), 32'd12);
    check("seq_p1_blocked2", 122, 32'(p1_ready), 32'd0);
    @(negedge clk);
    fifo_full = 0;
    #1;
    check("seq_p1_granted", 123, 32'(p1_ready), 32'd1);
    @(negedge clk);
    p1_valid = 0;
    #1;
    check("seq_level13", 124, 32'(level), 32'd13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_port_arbiter.md
FIFO_PORT_ARBITER -- requirements
Module: fifo_port_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data word width; SHALL match the FIFO data_in/data_out width.
REQ-002 Parameter DEPTH, default 16, FIFO entry count; power of two, 2 to 256.
REQ-003 Parameter AF_LEVEL, default 12, almost-full interrupt threshold; 1 to DEPTH.
REQ-004 One clock, clk; reset rst is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 p0_valid / p1_valid  in  1  producer 0/1 has a word to write.
REQ-008 p0_data / p1_data  in  WIDTH  producer 0/1 write data.
REQ-009 p0_ready / p1_ready  out  1  producer 0/1 word accepted this cycle.
REQ-010 c_req  in  1  consumer requests one word.
REQ-011 c_valid  out  1  c_data holds a popped word.
REQ-012 c_data  out  WIDTH  popped word.
REQ-013 fifo_wr_en  out  1  write strobe to FIFO.
REQ-014 fifo_data_in  out  WIDTH  write data to FIFO.
REQ-015 fifo_rd_en  out  1  read strobe to FIFO.
REQ-016 fifo_data_out  in  WIDTH  FIFO read data, valid one cycle after fifo_rd_en.
REQ-017 fifo_full / fifo_empty  in  1  FIFO status flags.
REQ-018 level  out  $clog2(DEPTH)+1  tracked FIFO occupancy.
REQ-019 irq  out  1  almost-full interrupt.

Function
REQ-020 Write arbitration SHALL be round-robin between p0 and p1, with one grant at most per cycle.
REQ-021 Arbitration: only one valid -> grant it; both valid -> grant the producer not granted last; neither -> no grant, last-grant pointer unchanged.
REQ-022 The last-grant pointer SHALL update only on an accepted transfer (grant with fifo_full=0).
REQ-023 px_ready = granted(x) AND NOT fifo_full AND NOT rst, combinational; a blocked grant does not advance the pointer.
REQ-024 fifo_wr_en = p0_ready OR p1_ready; fifo_data_in = data of the granted producer, else 0.
REQ-025 fifo_rd_en = c_req AND NOT fifo_empty AND NOT rst, combinational.
REQ-026 c_valid SHALL be fifo_rd_en registered (1-cycle latency); c_data = fifo_data_out when c_valid=1, else 0.
REQ-027 level: +1 on write only; -1 on read only; unchanged on simultaneous write and read, or on neither.
REQ-028 level SHALL never exceed DEPTH or go below 0; full/empty gating guarantees this, and an assertion SHALL flag any violation.
REQ-029 If FIFO is full and a read occurs in the same cycle, the write is still blocked because fifo_full is sampled as given.
REQ-030 irq SHALL be registered, set the cycle after level >= AF_LEVEL, and cleared the cycle after level < AF_LEVEL.
REQ-031 fifo_full / fifo_empty SHALL be trusted as the FIFO's registered flags; level is informational and does not gate strobes.

Reset
REQ-032 While rst=1: fifo_wr_en, fifo_rd_en, p0_ready, p1_ready = 0.
REQ-033 On reset: level=0, c_valid=0, c_data=0, irq=0, last-grant pointer = p1, so p0 wins the first contention.
REQ-034 Reset asserted mid-transfer SHALL discard any pending read return; c_valid=0 in the cycle after rst.

Verification
REQ-035 After reset, both producers valid continuously, FIFO never full -> grants alternate p0,p1,p0,p1; level increments 1 per cycle.
REQ-036 Only p1 valid for 4 cycles -> p1_ready=1 for all 4 cycles, p0_ready=0; 4 writes; level=4.
REQ-037 fifo_full=1 with both producers valid -> no ready, no wr_en; pointer holds; after full drops, the originally due producer is granted.
REQ-038 DEPTH=16, AF_LEVEL=12: 12 writes -> irq=1 one cycle after level=12; one read -> level=11, irq=0 the next cycle.
REQ-039 Write and read in the same cycle at level=5 -> level stays 5; c_valid=1 the next cycle with c_data = fifo_data_out.
REQ-040 c_req=1 with fifo_empty=1 -> fifo_rd_en=0, c_valid stays 0; rst pulsed after a read -> c_valid=0, level=0.
